// File: rtl/piso_frame_tx_pkg.sv
// Shared encodings for the framed serial transmit path and its matching deserialiser.
package piso_frame_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage : piso_frame_tx_pkg

// File: rtl/piso_frame_tx_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES clocks per serial bit and flags the last cycle of each bit.
module piso_frame_tx_bit_timer #(
   parameter int unsigned BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(BIT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clear || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // clear holds the timer idle so no stray bit_end escapes outside a frame
   assign bit_end = (r_cnt == LAST) && !clear;

endmodule : piso_frame_tx_bit_timer

// File: rtl/piso_frame_tx.sv
// Parallel-load serialiser: sends start bit, WIDTH data bits, stop bit on a line that idles high.
module piso_frame_tx
   import piso_frame_tx_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned BIT_CYCLES = 4,
   parameter int unsigned MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             abort,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_e           r_state, w_state_nx;
   logic             r_tx, w_tx_nx;
   logic             r_busy, w_busy_nx;
   logic             r_done, w_done_nx;
   logic             r_ready, w_ready_nx;
   logic [WIDTH-1:0] r_shift, w_shift_nx, w_shifted;
   logic [BW-1:0]    r_bitcnt, w_bitcnt_nx;
   logic             w_bit_end;
   logic             w_timer_clear;

   function automatic logic head_bit(input logic [WIDTH-1:0] s);
      return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
      return (MSB_FIRST != 0) ? (s << 1) : (s >> 1);
   endfunction

   assign w_timer_clear = (r_state == ST_IDLE) || abort;

   piso_frame_tx_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_timer_clear),
      .bit_end (w_bit_end)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_tx     <= LINE_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_tx     <= w_tx_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         r_ready  <= w_ready_nx;
         r_shift  <= w_shift_nx;
         r_bitcnt <= w_bitcnt_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_tx_nx     = r_tx;
      w_busy_nx   = r_busy;
      w_done_nx   = 1'b0;
      w_shift_nx  = r_shift;
      w_bitcnt_nx = r_bitcnt;
      w_shifted   = shift_once(r_shift);

      if (abort && (r_state != ST_IDLE)) begin
         w_state_nx  = ST_IDLE;
         w_tx_nx     = LINE_IDLE;
         w_busy_nx   = 1'b0;
         w_bitcnt_nx = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_tx_nx = LINE_IDLE;
               // abort in the same cycle blocks the load even though it is otherwise a no-op here
               if (load_valid && !abort) begin
                  w_shift_nx  = d;
                  w_state_nx  = ST_START;
                  w_tx_nx     = START_BIT;
                  w_busy_nx   = 1'b1;
                  w_bitcnt_nx = '0;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  w_state_nx = ST_DATA;
                  w_tx_nx    = head_bit(r_shift);
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bitcnt == LAST_BIT) begin
                     w_state_nx = ST_STOP;
                     w_tx_nx    = LINE_IDLE;
                  end else begin
                     w_shift_nx  = w_shifted;
                     w_bitcnt_nx = r_bitcnt + BW'(1);
                     w_tx_nx     = head_bit(w_shifted);
                  end
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  w_state_nx = ST_IDLE;
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
      end

      w_ready_nx = (w_state_nx == ST_IDLE);
   end

   assign load_ready = r_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule : piso_frame_tx

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: three configurations (MSB-first, LSB-first, one clock per bit).
module tb_piso_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   logic [7:0] d  = '0, d2 = '0, d3 = '0;
   logic       lv = 1'b0, lv2 = 1'b0, lv3 = 1'b0;
   logic       ab = 1'b0, ab2 = 1'b0, ab3 = 1'b0;
   logic       ready, tx, busy, done;
   logic       ready2, tx2, busy2, done2;
   logic       ready3, tx3, busy3, done3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .d(d), .load_valid(lv), .load_ready(ready),
      .abort(ab), .tx(tx), .busy(busy), .done(done));

   piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .d(d2), .load_valid(lv2), .load_ready(ready2),
      .abort(ab2), .tx(tx2), .busy(busy2), .done(done2));

   piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1)) dut_b1 (
      .clk(clk), .rst(rst), .d(d3), .load_valid(lv3), .load_ready(ready3),
      .abort(ab3), .tx(tx3), .busy(busy3), .done(done3));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; lv = 1'b1; d = 8'hA5;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rst_tx edge%0d got %b exp 1", i, tx); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy edge%0d got %b exp 0", i, busy); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done edge%0d got %b exp 0", i, done); end
      end
      rst = 1'b1; lv = 1'b0;
      step();
      checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got %b exp 1", ready); end
      checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL rst_ready_lsb got %b exp 1", ready2); end
      checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL rst_ready_bc1 got %b exp 1", ready3); end
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL rst_idle busy=%b tx=%b exp busy=0 tx=1", busy, tx); end
   endtask

   task automatic test_frame_a5();
      logic [9:0] exp = 10'b11_0100_1010;
      d = 8'hA5; lv = 1'b1;
      step();
      lv = 1'b0;
      for (int i = 0; i < 40; i++) begin
         checks++; if (tx !== exp[i/4]) begin errors++; $display("FAIL a5_tx cyc%0d got %b exp %b", i, tx, exp[i/4]); end
         checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL a5_busy cyc%0d got %b exp 1", i, busy); end
         checks++; if (done !== 1'b0)   begin errors++; $display("FAIL a5_early_done cyc%0d got %b exp 0", i, done); end
         checks++; if (ready !== 1'b0)  begin errors++; $display("FAIL a5_ready cyc%0d got %b exp 0", i, ready); end
         step();
      end
      checks++; if (done !== 1'b1)  begin errors++; $display("FAIL a5_done got %b exp 1", done); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL a5_busy_end got %b exp 0", busy); end
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL a5_tx_end got %b exp 1", tx); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL a5_ready_end got %b exp 1", ready); end
      step();
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL a5_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_lsb_ignore();
      logic [9:0] exp = 10'b10_0010_0110;
      d2 = 8'h13; lv2 = 1'b1;
      step();
      lv2 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         checks++; if (tx2 !== exp[i/4]) begin errors++; $display("FAIL lsb13_tx cyc%0d got %b exp %b", i, tx2, exp[i/4]); end
         checks++; if (busy2 !== 1'b1)   begin errors++; $display("FAIL lsb13_busy cyc%0d got %b exp 1", i, busy2); end
         if (i == 8)  begin d2 = 8'hFF; lv2 = 1'b1; end
         if (i == 20) lv2 = 1'b0;
         step();
      end
      checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL lsb13_done got %b exp 1", done2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL lsb13_busy_end got %b exp 0", busy2); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp1 = 10'b11_1100_1000;
      logic [9:0] exp2 = 10'b10_1011_0100;
      int t1;
      d = 8'h27; lv = 1'b1;
      step();
      d = 8'h5A;
      for (int i = 0; i < 40; i++) begin
         checks++; if (tx !== exp1[i/4]) begin errors++; $display("FAIL b2b1_tx cyc%0d got %b exp %b", i, tx, exp1[i/4]); end
         checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL b2b1_ready cyc%0d got %b exp 0", i, ready); end
         step();
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b1_done got %b exp 1", done); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL b2b_gap_tx got %b exp 1", tx); end
      t1 = cyc;
      step();
      for (int i = 0; i < 40; i++) begin
         checks++; if (tx !== exp2[i/4]) begin errors++; $display("FAIL b2b2_tx cyc%0d got %b exp %b", i, tx, exp2[i/4]); end
         checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL b2b2_ready cyc%0d got %b exp 0", i, ready); end
         checks++; if (done !== 1'b0)    begin errors++; $display("FAIL b2b2_early_done cyc%0d got %b exp 0", i, done); end
         step();
      end
      lv = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b2_done got %b exp 1", done); end
      checks++; if (cyc - t1 !== 41) begin errors++; $display("FAIL b2b_spacing got %0d exp 41", cyc - t1); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third got busy=%b exp 0", busy); end
   endtask

   task automatic test_abort();
      logic [9:0] exp  = 10'b11_0100_1010;
      logic [9:0] exp3 = 10'b10_0111_1000;
      d = 8'hA5; lv = 1'b1;
      step();
      lv = 1'b0;
      for (int i = 0; i < 18; i++) begin
         checks++; if (tx !== exp[i/4]) begin errors++; $display("FAIL abort_pre_tx cyc%0d got %b exp %b", i, tx, exp[i/4]); end
         if (i == 17) ab = 1'b1;
         step();
      end
      ab = 1'b0;
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL abort_tx got %b exp 1", tx); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL abort_done got %b exp 0", done); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", ready); end
      for (int i = 0; i < 45; i++) begin
         step();
         checks++; if (done !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL abort_quiet cyc%0d done=%b tx=%b exp done=0 tx=1", i, done, tx); end
      end
      d = 8'h3C; lv = 1'b1; ab = 1'b1;
      step();
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL abort_blocks_load busy=%b tx=%b exp busy=0 tx=1", busy, tx); end
      ab = 1'b0;
      step();
      lv = 1'b0;
      for (int i = 0; i < 40; i++) begin
         checks++; if (tx !== exp3[i/4]) begin errors++; $display("FAIL post_abort_tx cyc%0d got %b exp %b", i, tx, exp3[i/4]); end
         checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL post_abort_busy cyc%0d got %b exp 1", i, busy); end
         step();
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_abort_done got %b exp 1", done); end
   endtask

   task automatic test_reset_stop();
      d = 8'h3C; lv = 1'b1;
      step();
      lv = 1'b0;
      for (int i = 0; i < 37; i++) step();
      checks++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL rststop_in_stop busy=%b tx=%b exp busy=1 tx=1", busy, tx); end
      rst = 1'b0;
      step();
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rststop_tx got %b exp 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rststop_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rststop_done got %b exp 0", done); end
      step();
      rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rststop_quiet cyc%0d done=%b busy=%b exp 0 0", i, done, busy); end
      end
   endtask

   task automatic test_bc1();
      logic [9:0] exp = 10'b11_0000_0010;
      d3 = 8'h81; lv3 = 1'b1;
      step();
      lv3 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++; if (tx3 !== exp[i])  begin errors++; $display("FAIL bc1_tx cyc%0d got %b exp %b", i, tx3, exp[i]); end
         checks++; if (busy3 !== 1'b1)  begin errors++; $display("FAIL bc1_busy cyc%0d got %b exp 1", i, busy3); end
         checks++; if (done3 !== 1'b0)  begin errors++; $display("FAIL bc1_early_done cyc%0d got %b exp 0", i, done3); end
         step();
      end
      checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL bc1_done got %b exp 1", done3); end
      checks++; if (busy3 !== 1'b0 || tx3 !== 1'b1) begin errors++; $display("FAIL bc1_end busy=%b tx=%b exp busy=0 tx=1", busy3, tx3); end
      step();
      checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL bc1_done_pulse got %b exp 0", done3); end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_lsb_ignore();
      test_back_to_back();
      test_abort();
      test_reset_stop();
      test_bc1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_piso_frame_tx
